// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - pipeline stage register with valid/ready handshake, stall, flush and optional skid entry
//
// Purpose: registers one pipeline entry (control + payload) between two stages.
//          The head entry M drives the outputs; an optional skid entry S keeps
//          in_ready registered so no combinational path runs from out_ready.
// Build option: PIPE_STAGE_REG_SKID_EN - when defined, the skid entry S is built.
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   flush      synchronous wash of all stored entries (beats hold and transfers)
//   hold       stall: freezes all state, blocks accept and emit
//   in_valid   / in_ready / in_ctrl / in_data     upstream handshake and entry
//   out_valid  / out_ready / out_ctrl / out_data  downstream handshake and entry
//   occupancy  number of stored entries
module pipe_stage_reg #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              hold,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    logic              m_valid;
    logic [CTRL_W-1:0] m_ctrl;
    logic [DATA_W-1:0] m_data;

    logic accept;
    logic emit;

    assign emit   = m_valid && out_ready && !hold;
    assign accept = in_valid && in_ready;

`ifdef PIPE_STAGE_REG_SKID_EN

    logic              s_valid;
    logic [CTRL_W-1:0] s_ctrl;
    logic [DATA_W-1:0] s_data;

    // Ready depends only on registers: S empty guarantees room for one more
    // entry even if downstream stalls this cycle.
    assign in_ready = !s_valid && !hold;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_valid <= 1'b0;
            m_ctrl  <= '0;
            m_data  <= '0;
            s_valid <= 1'b0;
            s_ctrl  <= '0;
            s_data  <= '0;
        end else if (flush) begin
            m_valid <= 1'b0;
            m_ctrl  <= '0;
            m_data  <= '0;
            s_valid <= 1'b0;
            s_ctrl  <= '0;
            s_data  <= '0;
        end else if (emit) begin
            if (s_valid) begin
                // S is older than anything upstream; accept is blocked while S is full.
                m_ctrl  <= s_ctrl;
                m_data  <= s_data;
                s_valid <= 1'b0;
            end else if (accept) begin
                m_ctrl <= in_ctrl;
                m_data <= in_data;
            end else begin
                m_valid <= 1'b0;
            end
        end else if (accept) begin
            if (m_valid) begin
                s_valid <= 1'b1;
                s_ctrl  <= in_ctrl;
                s_data  <= in_data;
            end else begin
                m_valid <= 1'b1;
                m_ctrl  <= in_ctrl;
                m_data  <= in_data;
            end
        end
    end

    assign occupancy = {1'b0, m_valid} + {1'b0, s_valid};

`else

    // Without a skid entry the stage can only take a new entry when the head
    // leaves in the same edge, so ready looks through to out_ready.
    assign in_ready = (!m_valid || out_ready) && !hold;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_valid <= 1'b0;
            m_ctrl  <= '0;
            m_data  <= '0;
        end else if (flush) begin
            m_valid <= 1'b0;
            m_ctrl  <= '0;
            m_data  <= '0;
        end else if (accept) begin
            m_valid <= 1'b1;
            m_ctrl  <= in_ctrl;
            m_data  <= in_data;
        end else if (emit) begin
            m_valid <= 1'b0;
        end
    end

    assign occupancy = {1'b0, m_valid};

`endif

    assign out_valid = m_valid;
    // A bubble must never carry live control bits (regwr, memwr, ...).
    assign out_ctrl  = m_valid ? m_ctrl : '0;
    assign out_data  = m_data;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - scoreboard testbench for pipe_stage_reg
module tb_pipe_stage_reg;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        hold;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_ctrl;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_ctrl;
    logic [31:0] out_data;
    logic [1:0]  occupancy;

    int checks   = 0;
    int failures = 0;
    int emit_count = 0;
    logic [47:0] exp_q[$];

    pipe_stage_reg #(.DATA_W(32), .CTRL_W(16)) dut (
        .clk(clk), .reset(rst_n), .flush(flush), .hold(hold),
        .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
        .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every downstream transfer.
    always @(negedge clk) begin
        if (rst_n && !out_valid)
            chk("bubble_ctrl_zero", 64'(out_ctrl), 64'h0);
        if (rst_n && out_valid && out_ready && !hold && !flush) begin
            emit_count++;
            if (exp_q.size() == 0) begin
                chk("unexpected_emit", 64'({out_ctrl, out_data}), 64'hDEAD);
            end else begin
                logic [47:0] e;
                e = exp_q.pop_front();
                chk("emit_ctrl", 64'(out_ctrl), 64'(e[47:32]));
                chk("emit_data", 64'(out_data), 64'(e[31:0]));
            end
        end
    end

    // Entered just after a rising edge; returns just after the edge that took the entry.
    task automatic send(input logic [15:0] c, input logic [31:0] d);
        bit done;
        done = 0;
        in_valid = 1'b1;
        in_ctrl  = c;
        in_data  = d;
        for (int k = 0; k < 64 && !done; k++) begin
            @(negedge clk);
            if (in_ready && !flush) begin
                exp_q.push_back({c, d});
                done = 1;
            end
            @(posedge clk);
            #1;
        end
        if (!done) chk("send_timeout", 64'h0, 64'h1);
        in_valid = 1'b0;
        in_ctrl  = '0;
        in_data  = '0;
    endtask

    task automatic drain(input string name);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 64) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk(name, 64'(exp_q.size()), 64'h0);
    endtask

    initial begin
        int e0;
        bit mv, er, em;
        rst_n = 1'b0; flush = 1'b0; hold = 1'b0;
        in_valid = 1'b0; in_ctrl = '0; in_data = '0; out_ready = 1'b1;

        // Reset state
        #12;
        chk("rst_out_valid", 64'(out_valid), 64'h0);
        chk("rst_out_ctrl",  64'(out_ctrl),  64'h0);
        chk("rst_out_data",  64'(out_data),  64'h0);
        chk("rst_occupancy", 64'(occupancy), 64'h0);
        chk("rst_in_ready",  64'(in_ready),  64'h1);
        @(posedge clk); #3 rst_n = 1'b1;
        @(posedge clk); #1;

        // Single entry, one-cycle latency
        send(16'h0003, 32'h12345678);
        @(negedge clk);
        chk("lat_out_valid", 64'(out_valid), 64'h1);
        chk("lat_out_data",  64'(out_data),  64'h12345678);
        chk("lat_out_ctrl",  64'(out_ctrl),  64'h0003);
        chk("lat_occupancy", 64'(occupancy), 64'h1);
        @(posedge clk); #1;
        drain("drain_single");

        // Stream 1..8 with a two-cycle downstream stall
        out_ready = 1'b0;
        fork
            for (int i = 1; i <= 8; i++) send(16'(i), 32'(i));
            begin
                @(posedge clk);
                @(posedge clk);
                @(negedge clk);
`ifdef PIPE_STAGE_REG_SKID_EN
                chk("stall_occupancy", 64'(occupancy), 64'h2);
`else
                chk("stall_occupancy", 64'(occupancy), 64'h1);
`endif
                chk("stall_in_ready", 64'(in_ready), 64'h0);
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        e0 = emit_count;
        drain("drain_stream");

        // Flush with an entry presented in the flush cycle
        out_ready = 1'b0;
        send(16'h0011, 32'h11);
`ifdef PIPE_STAGE_REG_SKID_EN
        send(16'h0022, 32'h22);
        chk("pre_flush_occ", 64'(occupancy), 64'h2);
`else
        chk("pre_flush_occ", 64'(occupancy), 64'h1);
`endif
        flush = 1'b1; in_valid = 1'b1; in_ctrl = 16'h000F; in_data = 32'hAA;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0; in_ctrl = '0; in_data = '0;
        exp_q.delete();
        @(negedge clk);
        chk("flush_out_valid", 64'(out_valid), 64'h0);
        chk("flush_out_ctrl",  64'(out_ctrl),  64'h0);
        chk("flush_occupancy", 64'(occupancy), 64'h0);
        chk("flush_in_ready",  64'(in_ready),  64'h1);
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;

        // Hold freezes a stored entry
        out_ready = 1'b0;
        send(16'h0005, 32'h55);
        hold = 1'b1; out_ready = 1'b1;
        e0 = emit_count;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("hold_out_data",  64'(out_data),  64'h55);
            chk("hold_out_valid", 64'(out_valid), 64'h1);
            chk("hold_in_ready",  64'(in_ready),  64'h0);
            @(posedge clk); #1;
        end
        chk("hold_no_emit", 64'(emit_count - e0), 64'h0);
        hold = 1'b0;
        @(posedge clk); #1;
        chk("hold_emit_once", 64'(emit_count - e0), 64'h1);
        @(negedge clk);
        chk("hold_after_valid", 64'(out_valid), 64'h0);
        @(posedge clk); #1;

        // Asynchronous reset mid-stream
        out_ready = 1'b0;
        send(16'h00A1, 32'hA1);
`ifdef PIPE_STAGE_REG_SKID_EN
        send(16'h00A2, 32'hA2);
`endif
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 64'(out_valid), 64'h0);
        chk("arst_out_ctrl",  64'(out_ctrl),  64'h0);
        chk("arst_out_data",  64'(out_data),  64'h0);
        chk("arst_occupancy", 64'(occupancy), 64'h0);
        exp_q.delete();
        @(posedge clk); #3 rst_n = 1'b1;
        #1;
        chk("arst_in_ready", 64'(in_ready), 64'h1);
        @(posedge clk); #1;
        out_ready = 1'b1;
        send(16'h0007, 32'h77);
        drain("drain_after_reset");
        repeat (2) @(posedge clk);
        #1;

`ifndef PIPE_STAGE_REG_SKID_EN
        // Toggling out_ready: ready must look through combinationally
        mv = 1'b0;
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1; in_ctrl = 16'(i); in_data = 32'h100 + 32'(i);
            out_ready = 1'b0;
            #1 chk("comb_ready_lo", 64'(in_ready), 64'(!mv));
            out_ready = i[0];
            #1;
            er = !mv || out_ready;
            em = mv && out_ready;
            chk("comb_ready", 64'(in_ready), 64'(er));
            @(negedge clk);
            chk("occ_le_1", 64'(occupancy <= 2'd1), 64'h1);
            if (er) exp_q.push_back({in_ctrl, in_data});
            @(posedge clk); #1;
            mv = er ? 1'b1 : (em ? 1'b0 : mv);
        end
        in_valid = 1'b0; in_ctrl = '0; in_data = '0;
        out_ready = 1'b1;
        drain("drain_toggle");
`endif

        @(posedge clk); #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, named as the codebase names them: clk and reset.
REQ-002 The block SHALL have parameter DATA_W, default 32, width of the payload bus (operands, immediates, addresses).
REQ-003 The block SHALL have parameter CTRL_W, default 16, width of the control bus (regwr, memwr, op codes and similar).
REQ-004 The block SHALL have port clk, input, 1, rising-edge clock.
REQ-005 The block SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-006 The block SHALL have port flush, input, 1, synchronous wash of all stored entries.
REQ-007 The block SHALL have port hold, input, 1, freezes the stage (stall).
REQ-008 The block SHALL have port in_valid, input, 1, upstream entry present.
REQ-009 The block SHALL have port in_ready, output, 1, stage can accept an entry.
REQ-010 The block SHALL have port in_ctrl, input, CTRL_W, upstream control bits.
REQ-011 The block SHALL have port in_data, input, DATA_W, upstream payload.
REQ-012 The block SHALL have port out_valid, output, 1, downstream entry present.
REQ-013 The block SHALL have port out_ready, input, 1, downstream accepts the entry.
REQ-014 The block SHALL have port out_ctrl, output, CTRL_W, control bits of the head entry, all zeros when out_valid=0.
REQ-015 The block SHALL have port out_data, output, DATA_W, payload of the head entry.
REQ-016 The block SHALL have port occupancy, output, 2, number of stored entries (0..2).

Function
REQ-017 Storage SHALL be a main entry M (drives outputs) plus a skid entry S, each with its own valid bit.
REQ-018 Accept SHALL occur when in_valid && in_ready; emit SHALL occur when out_valid && out_ready && !hold.
REQ-019 in_ready SHALL be !S.valid && !hold, decoded from registers only, with no combinational path from out_ready.
REQ-020 Latency SHALL be 1 cycle: an entry accepted while empty appears on out_valid at the next edge.
REQ-021 Throughput SHALL be 1 entry per cycle while out_ready=1; order SHALL be strictly FIFO.
REQ-022 On accept with M full and no emit, the entry SHALL go to S; on emit with S valid, S SHALL move to M in the same edge.
REQ-023 On simultaneous accept and emit with S empty, the new entry SHALL replace M directly.
REQ-024 out_ctrl SHALL be forced to zero whenever out_valid=0, so a bubble never carries regwr/memwr.
REQ-025 While hold=1, all state SHALL be frozen, in_ready=0, and no emit SHALL be counted even if out_ready=1.
REQ-026 flush SHALL take priority over hold and transfers; at the edge it SHALL clear M.valid and S.valid and zero the stored ctrl and data.
REQ-027 An entry presented in the flush cycle SHALL be discarded, and in_ready SHALL be 1 in the cycle after flush (unless hold=1).
REQ-028 occupancy SHALL equal M.valid + S.valid; S.valid=1 with M.valid=0 SHALL be unreachable.

Reset
REQ-029 Reset assertion SHALL immediately clear both valids, zero all ctrl and data, and give out_valid=0, out_ctrl=0, out_data=0, occupancy=0, in_ready=1.
REQ-030 Reset asserted mid-transfer SHALL drop all entries; the first accept after reset deassertion SHALL be at the first clean edge.

Configuration
REQ-031 Macro PIPE_STAGE_REG_SKID_EN SHALL select the skid entry: when defined, behaviour SHALL be as above.
REQ-032 When PIPE_STAGE_REG_SKID_EN is undefined, S SHALL NOT be built; in_ready SHALL be (!M.valid || out_ready) && !hold (combinational from out_ready); occupancy SHALL be at most 1.

Verification
REQ-033 Empty stage, in_valid=1, in_data=0x12345678, in_ctrl=0x0003, out_ready=1 -> next cycle out_valid=1, out_data=0x12345678, out_ctrl=0x0003, occupancy=1.
REQ-034 Stream 0x1..0x8 with out_ready=0 for 2 cycles then 1 -> occupancy reaches 2, in_ready=0, outputs 0x1..0x8 in order with no loss or duplication.
REQ-035 Two entries stored, flush=1 with in_valid=1, in_data=0xAA -> next cycle out_valid=0, out_ctrl=0, occupancy=0, 0xAA never emitted.
REQ-036 One entry held, hold=1 for 3 cycles with out_ready=1 -> out_data stable, in_ready=0, no emit; hold=0 -> emitted exactly once.
REQ-037 reset driven low mid-stream with occupancy=2 -> outputs zero immediately without a clock edge, in_ready=1 after release.
REQ-038 Macro undefined, out_ready toggling every cycle with continuous input -> in_ready follows out_ready combinationally and occupancy never exceeds 1.
